// File: rtl/wram_banked_if.sv
// CPU/SVBK/DMA bus for the banked work RAM.
// The master drives requests; the slave (RAM) returns read data and busy.
interface wram_banked_if;
    logic        cpu_en;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic        write;
    logic [7:0]  rdata;
    logic        svbk_sel;
    logic [7:0]  svbk_rdata;
    logic        dma_en;
    logic [12:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic        busy;

    modport master (
        output cpu_en, addr, wdata, write, svbk_sel, dma_en, dma_addr,
        input  rdata, svbk_rdata, dma_rdata, busy
    );

    modport slave (
        input  cpu_en, addr, wdata, write, svbk_sel, dma_en, dma_addr,
        output rdata, svbk_rdata, dma_rdata, busy
    );
endinterface

// File: rtl/wram_banked.sv
// Banked work RAM (C000-DFFF) with SVBK bank register, a DMA read port,
// registered reads, and a sequential clear engine that runs after reset.
module wram_banked #(
    parameter int unsigned BANK_BITS   = 3,
    parameter logic [7:0]  CLEAR_VALUE = 8'h00,
    parameter bit          CGB_MODE    = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    wram_banked_if.slave bus
);
    localparam int unsigned AW        = BANK_BITS + 12;
    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [7:0]  SVBK_MASK = 8'((1 << BANK_BITS) - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t               state, state_nxt;
    logic [AW-1:0]        clr_cnt;
    logic [BANK_BITS-1:0] svbk, svbk_eff;
    logic [7:0]           mem [DEPTH];
    logic                 busy, clr_we, cpu_rd, cpu_wr, svbk_wr;
    logic [AW-1:0]        cpu_phys, dma_phys;

    // Upper half of the window is the switchable bank; lower half is bank 0.
    function automatic logic [AW-1:0] map_addr(input logic [12:0] a,
                                               input logic [BANK_BITS-1:0] bank);
        return {(a[12] ? bank : {BANK_BITS{1'b0}}), a[11:0]};
    endfunction

    always_comb begin
        svbk_eff = svbk;
        if (!CGB_MODE || svbk == '0)
            svbk_eff = BANK_BITS'(1);
    end

    assign cpu_phys = map_addr(bus.addr, svbk_eff);
    assign dma_phys = map_addr(bus.dma_addr, svbk_eff);

    assign busy    = (state == CLEAR);
    assign clr_we  = busy & ~reset;
    assign cpu_rd  = bus.cpu_en & ~bus.write & ~bus.svbk_sel;
    assign cpu_wr  = bus.cpu_en &  bus.write & ~bus.svbk_sel & ~busy & ~reset;
    assign svbk_wr = bus.cpu_en &  bus.write &  bus.svbk_sel;

    // Clear engine
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (busy && clr_cnt != '1)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == '1) state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    // SVBK register; still writable while the clear runs.
    always_ff @(posedge clk) begin
        if (reset)
            svbk <= '0;
        else if (svbk_wr && CGB_MODE)
            svbk <= bus.wdata[BANK_BITS-1:0];
    end

    assign bus.svbk_rdata = CGB_MODE ? (8'(svbk) | ~SVBK_MASK) : 8'hFF;
    assign bus.busy       = busy;

    // Single write port shared by the clear engine and the CPU.
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_cnt] <= CLEAR_VALUE;
        else if (cpu_wr)
            mem[cpu_phys] <= bus.wdata;
    end

    // Reads see the pre-write contents, giving read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (reset)
            bus.rdata <= 8'hFF;
        else if (cpu_rd)
            bus.rdata <= busy ? 8'hFF : mem[cpu_phys];
    end

    always_ff @(posedge clk) begin
        if (reset)
            bus.dma_rdata <= 8'hFF;
        else if (bus.dma_en)
            bus.dma_rdata <= busy ? 8'hFF : mem[dma_phys];
    end
endmodule

// File: tb/tb_wram_banked.sv
// Bench for wram_banked: directed steps plus a randomized phase checked
// against an array model of the banked address space.
module tb_wram_banked;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wram_banked_if bus ();
    wram_banked_if dbus ();

    wram_banked #(.BANK_BITS(3), .CLEAR_VALUE(8'h00), .CGB_MODE(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    wram_banked #(.BANK_BITS(1), .CLEAR_VALUE(8'h00), .CGB_MODE(1'b0)) dut_dmg (
        .clk(clk), .reset(reset), .bus(dbus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mdl [32768];
    int         svbk_m = 0;

    function automatic int phys(input int a, input int sv);
        int eff;
        eff = (sv == 0) ? 1 : sv;
        if (a >= 4096) return eff * 4096 + (a % 4096);
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_en = 1'b0; bus.write = 1'b0; bus.svbk_sel = 1'b0; bus.dma_en = 1'b0;
    endtask

    task automatic cpu_wr(input logic [12:0] a, input logic [7:0] d);
        bus.cpu_en = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wdata = d;
        tick(); idle();
        mdl[phys(int'(a), svbk_m)] = d;
    endtask

    task automatic cpu_rd(input logic [12:0] a, output logic [7:0] d);
        bus.cpu_en = 1'b1; bus.addr = a;
        tick(); d = bus.rdata; idle();
    endtask

    task automatic dma_rd(input logic [12:0] a, output logic [7:0] d);
        bus.dma_en = 1'b1; bus.dma_addr = a;
        tick(); d = bus.dma_rdata; idle();
    endtask

    task automatic svbk_wr(input logic [7:0] d);
        bus.cpu_en = 1'b1; bus.write = 1'b1; bus.svbk_sel = 1'b1; bus.wdata = d;
        tick(); idle();
        svbk_m = int'(d) % 8;
    endtask

    task automatic d_op(input logic en, input logic wr, input logic sel,
                        input logic [12:0] a, input logic [7:0] d, input logic den);
        dbus.cpu_en = en; dbus.write = wr; dbus.svbk_sel = sel; dbus.addr = a;
        dbus.dma_addr = a; dbus.wdata = d; dbus.dma_en = den;
        tick();
        dbus.cpu_en = 1'b0; dbus.write = 1'b0; dbus.svbk_sel = 1'b0; dbus.dma_en = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 40000) begin
            tick(); n++;
        end
        check(tag, n, 32768);
    endtask

    initial begin
        logic [7:0]  d, exp_r, exp_d, wd;
        logic [12:0] a, da;
        logic        ce, wr, sel, de;
        int          n;

        for (int i = 0; i < 32768; i++) mdl[i] = 8'h00;
        idle();
        bus.addr = '0; bus.dma_addr = '0; bus.wdata = '0;
        dbus.cpu_en = 1'b0; dbus.write = 1'b0; dbus.svbk_sel = 1'b0; dbus.dma_en = 1'b0;
        dbus.addr = '0; dbus.dma_addr = '0; dbus.wdata = '0;

        // Reset state
        #1 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_rdata", bus.rdata, 8'hFF);
        check("rst_dma_rdata", bus.dma_rdata, 8'hFF);
        check("rst_busy", bus.busy, 1'b1);
        check("rst_svbk", bus.svbk_rdata, 8'hF8);
        check("rst_dmg_svbk", dbus.svbk_rdata, 8'hFF);

        // Full clear, with accesses injected while busy
        n = 0;
        while (bus.busy === 1'b1 && n < 40000) begin
            idle();
            case (n)
                100: begin bus.cpu_en = 1'b1; bus.write = 1'b1; bus.addr = 13'h0010; bus.wdata = 8'h5A; end
                101: begin bus.cpu_en = 1'b1; bus.addr = 13'h0010; end
                102: begin bus.dma_en = 1'b1; bus.dma_addr = 13'h0010; end
                103: begin bus.cpu_en = 1'b1; bus.write = 1'b1; bus.svbk_sel = 1'b1; bus.wdata = 8'h05; end
                104: begin bus.cpu_en = 1'b1; bus.write = 1'b1; bus.svbk_sel = 1'b1; bus.wdata = 8'h00; end
                default: ;
            endcase
            tick(); n++;
            if (n == 102) check("busy_cpu_rd", bus.rdata, 8'hFF);
            if (n == 103) check("busy_dma_rd", bus.dma_rdata, 8'hFF);
            if (n == 104) check("busy_svbk_wr", bus.svbk_rdata, 8'hFD);
            if (n == 105) check("busy_svbk_clr", bus.svbk_rdata, 8'hF8);
        end
        idle();
        check("clear_cycles", n, 32768);
        check("clear_busy_low", bus.busy, 1'b0);
        check("dmg_busy_low", dbus.busy, 1'b0);

        cpu_rd(13'h0000, d); check("clr_0000", d, 8'h00);
        cpu_rd(13'h1FFF, d); check("clr_1FFF", d, 8'h00);
        cpu_rd(13'h0010, d); check("busy_wr_lost", d, 8'h00);
        for (int b = 1; b < 8; b++) begin
            svbk_wr(8'(b));
            cpu_rd(13'h1800, d); check($sformatf("clr_bank%0d", b), d, 8'h00);
        end
        svbk_wr(8'h00);

        // Bank 0 alias of SVBK=0 and SVBK=1
        cpu_wr(13'h1000, 8'hA5);
        svbk_wr(8'h01); cpu_rd(13'h1000, d); check("svbk1_rd", d, 8'hA5);
        svbk_wr(8'h02); cpu_rd(13'h1000, d); check("svbk2_rd", d, 8'h00);
        svbk_wr(8'h00); cpu_rd(13'h1000, d); check("svbk0_rd", d, 8'hA5);

        // Fixed bank 0 is independent of SVBK
        cpu_wr(13'h0123, 8'h3C);
        for (int b = 1; b < 8; b++) begin
            svbk_wr(8'(b));
            cpu_rd(13'h0123, d); check($sformatf("bank0_svbk%0d", b), d, 8'h3C);
        end
        svbk_wr(8'hFF);
        check("svbk_ff", bus.svbk_rdata, 8'hFF);
        cpu_wr(13'h1234, 8'hE7);
        svbk_wr(8'h07); cpu_rd(13'h1234, d); check("svbk_ff_is7", d, 8'hE7);
        svbk_wr(8'h06); cpu_rd(13'h1234, d); check("svbk6_other", d, mdl[phys(13'h1234, 6)]);

        // CPU write and DMA read collide on the same address
        svbk_wr(8'h00);
        cpu_wr(13'h1010, 8'h11);
        bus.cpu_en = 1'b1; bus.write = 1'b1; bus.addr = 13'h1010; bus.wdata = 8'h77;
        bus.dma_en = 1'b1; bus.dma_addr = 13'h1010;
        tick(); idle();
        mdl[phys(13'h1010, svbk_m)] = 8'h77;
        check("collide_old", bus.dma_rdata, 8'h11);
        dma_rd(13'h1010, d); check("collide_new", d, 8'h77);

        // DMG build: banking disabled, bank 1 fixed
        d_op(1'b1, 1'b1, 1'b1, 13'h0000, 8'h03, 1'b0);
        check("dmg_svbk_rd", dbus.svbk_rdata, 8'hFF);
        d_op(1'b1, 1'b1, 1'b0, 13'h1000, 8'h42, 1'b0);
        d_op(1'b1, 1'b0, 1'b0, 13'h1000, 8'h00, 1'b0);
        check("dmg_bank1_cpu", dbus.rdata, 8'h42);
        d_op(1'b0, 1'b0, 1'b0, 13'h1000, 8'h00, 1'b1);
        check("dmg_bank1_dma", dbus.dma_rdata, 8'h42);
        d_op(1'b0, 1'b1, 1'b0, 13'h0000, 8'h99, 1'b0);
        d_op(1'b1, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b0);
        check("dmg_en0_write", dbus.rdata, 8'h00);

        // Randomized traffic against the model
        cpu_rd(13'h0000, d); exp_r = mdl[0]; check("rnd_seed_r", d, exp_r);
        dma_rd(13'h0000, d); exp_d = mdl[0]; check("rnd_seed_d", d, exp_d);
        for (int i = 0; i < 2000; i++) begin
            a   = (($urandom % 2) != 0 ? 13'h1000 : 13'h0000) | 13'($urandom % 64);
            da  = (($urandom % 2) != 0 ? 13'h1000 : 13'h0000) | 13'($urandom % 64);
            ce  = ($urandom % 4) != 0;
            wr  = 1'($urandom % 2);
            sel = ($urandom % 8) == 0;
            de  = 1'($urandom % 2);
            wd  = 8'($urandom);
            bus.cpu_en = ce; bus.write = wr; bus.svbk_sel = sel; bus.addr = a;
            bus.wdata = wd; bus.dma_en = de; bus.dma_addr = da;
            if (de) exp_d = mdl[phys(int'(da), svbk_m)];
            if (ce && !sel && !wr) exp_r = mdl[phys(int'(a), svbk_m)];
            if (ce && !sel && wr) mdl[phys(int'(a), svbk_m)] = wd;
            if (ce && sel && wr) svbk_m = int'(wd) % 8;
            tick();
            check("rnd_rdata", bus.rdata, exp_r);
            check("rnd_dma_rdata", bus.dma_rdata, exp_d);
            check("rnd_svbk", bus.svbk_rdata, 8'hF8 | 8'(svbk_m));
        end
        idle();

        // Reset in the middle of a clear restarts it
        svbk_wr(8'h00);
        cpu_wr(13'h0010, 8'h5A);
        cpu_rd(13'h0010, d); check("pre_rst_wr", d, 8'h5A);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst2_rdata", bus.rdata, 8'hFF);
        check("rst2_svbk", bus.svbk_rdata, 8'hF8);
        svbk_m = 0;
        repeat (5000) tick();
        check("mid_clear_busy", bus.busy, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        count_busy("restart_cycles");
        cpu_rd(13'h0010, d); check("post_rst_0010", d, 8'h00);
        cpu_rd(13'h1010, d); check("post_rst_1010", d, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
